counter_sched: RTL and testbench

Sequencing controller for a free-running `counter` instance with parameter BW. The counter has only a clock, an asynchronous reset and a synchronous active-low clear. This block gates the counter through that clear, watches count_i against a latched period, and emits period ticks. It supports a fixed number of periods or continuous operation, and is the programmable timer front-end for the counter datapath.

---
 rtl/counter_sched.sv | 114 +++++++++++
 tb/tb_counter_sched.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/counter_sched.sv
// counter_sched: sequencing controller for a free-running counter.
// Holds the counter cleared through its synchronous clear outside RUN, watches
// count_i against a period latched at start, emits one tick per completed
// period and stops after a programmed number of periods (0 = run forever).
module counter_sched #(
  parameter int unsigned BW = 4,
  parameter int unsigned PW = 8
) (
  input  logic          clk_i,
  input  logic          nrst_i,
  input  logic          start_i,
  input  logic          stop_i,
  input  logic [BW-1:0] period_i,
  input  logic [PW-1:0] reps_i,
  input  logic [BW-1:0] count_i,
  output logic          cntNrstSync_o,
  output logic          tick_o,
  output logic          busy_o,
  output logic          done_o,
  output logic [PW-1:0] periods_o
);

  typedef enum logic [1:0] {
    StIdle,
    StArm,
    StRun,
    StDone
  } state_e;

  state_e        state_q, state_d;
  logic [BW-1:0] period_q, period_d;
  logic [PW-1:0] reps_q, reps_d;
  logic [PW-1:0] periods_q, periods_d;

  logic          match;
  logic          in_run;
  logic [PW-1:0] periods_inc;
  logic          last_period;

  // Terminal-count compare and period bookkeeping shared by next-state and outputs.
  always_comb begin
    match       = (count_i == period_q);
    in_run      = (state_q == StRun);
    periods_inc = periods_q + PW'(1);
    // reps_q == 0 selects continuous mode, so it never ends a run.
    last_period = (reps_q != '0) && (periods_inc == reps_q);
  end

  // Next-state logic and latching of the run configuration.
  always_comb begin
    state_d   = state_q;
    period_d  = period_q;
    reps_d    = reps_q;
    periods_d = periods_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          period_d  = period_i;
          reps_d    = reps_i;
          periods_d = '0;
          state_d   = StArm;
        end
      end
      StArm: begin
        // One cycle with the clear held guarantees the counter enters RUN at 0.
        state_d = stop_i ? StIdle : StRun;
      end
      StRun: begin
        // A match still counts when stop coincides with it; stop only wins the transition.
        if (match) begin
          periods_d = periods_inc;
        end
        if (stop_i) begin
          state_d = StIdle;
        end else if (match && last_period) begin
          state_d = StDone;
        end
      end
      StDone: begin
        // start_i is deliberately ignored here; a held start is taken in the next IDLE.
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and configuration registers, cleared asynchronously.
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      state_q   <= StIdle;
      period_q  <= '0;
      reps_q    <= '0;
      periods_q <= '0;
    end else begin
      state_q   <= state_d;
      period_q  <= period_d;
      reps_q    <= reps_d;
      periods_q <= periods_d;
    end
  end

  // Output decode: the counter runs only in RUN and is cleared on the match edge,
  // which also covers the all-ones period where clear and natural wrap coincide.
  always_comb begin
    cntNrstSync_o = in_run && !match;
    tick_o        = in_run && match;
    busy_o        = (state_q != StIdle);
    done_o        = (state_q == StDone);
    periods_o     = periods_q;
  end

endmodule

// File: tb/tb_counter_sched.sv
// Bench for counter_sched: drives a behavioural counter through the block's
// clear output and scoreboards expected tick/done cycles per run.
module tb_counter_sched;

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [3:0] period = '0;
  logic [7:0] reps = '0;
  logic [3:0] count;
  logic       cnt_nrst;
  logic       tick;
  logic       busy;
  logic       done;
  logic [7:0] periods;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int a = 0;

  typedef struct {
    int         cyc;
    logic [3:0] cnt;
    logic [7:0] per;
  } tick_t;

  tick_t tq[$];
  int    dq[$];

  counter_sched #(
    .BW(4),
    .PW(8)
  ) dut (
    .clk_i        (clk),
    .nrst_i       (nrst),
    .start_i      (start),
    .stop_i       (stop),
    .period_i     (period),
    .reps_i       (reps),
    .count_i      (count),
    .cntNrstSync_o(cnt_nrst),
    .tick_o       (tick),
    .busy_o       (busy),
    .done_o       (done),
    .periods_o    (periods)
  );

  always #5 clk = ~clk;

  // Controlled counter: async reset, synchronous active-low clear.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) count <= '0;
    else if (!cnt_nrst) count <= '0;
    else count <= count + 4'd1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // Expected ticks of one run armed at cycle arm: first at arm+1+p, then every p+1.
  task automatic push_run(input int arm, input int p, input int r, input int nticks,
                          input bit with_done);
    tick_t e;
    for (int k = 0; k < nticks; k++) begin
      e.cyc = arm + 1 + p + k * (p + 1);
      e.cnt = 4'(p);
      e.per = 8'(k);
      tq.push_back(e);
    end
    if (with_done) dq.push_back(arm + r * (p + 1) + 1);
  endtask

  // Advance one clock, sample #1 after the edge, compare against the scoreboard.
  task automatic step();
    bit    exp_tick;
    bit    exp_done;
    tick_t e;
    @(posedge clk);
    #1;
    cyc++;
    exp_tick = (tq.size() > 0) && (tq[0].cyc == cyc);
    exp_done = (dq.size() > 0) && (dq[0] == cyc);
    chk("tick", 32'(tick), 32'(exp_tick));
    chk("done", 32'(done), 32'(exp_done));
    if (exp_tick) begin
      e = tq.pop_front();
      chk("tick_count", 32'(count), 32'(e.cnt));
      chk("tick_periods", 32'(periods), 32'(e.per));
    end
    if (exp_done) begin
      void'(dq.pop_front());
      chk("done_nrst", 32'(cnt_nrst), 32'd0);
    end
  endtask

  task automatic start_run(input int p, input int r, output int arm);
    period = 4'(p);
    reps   = 8'(r);
    start  = 1'b1;
    step();
    start  = 1'b0;
    arm    = cyc;
    chk("arm_busy", 32'(busy), 32'd1);
    chk("arm_nrst", 32'(cnt_nrst), 32'd0);
  endtask

  initial begin
    // Reset state.
    #12;
    chk("rst_nrst", 32'(cnt_nrst), 32'd0);
    chk("rst_tick", 32'(tick), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_periods", 32'(periods), 32'd0);
    nrst = 1'b1;
    step();
    step();
    chk("idle_nrst", 32'(cnt_nrst), 32'd0);

    // 1: period 5, three periods.
    start_run(5, 3, a);
    push_run(a, 5, 3, 3, 1'b1);
    repeat (20) step();
    chk("t1_busy", 32'(busy), 32'd0);
    chk("t1_nrst", 32'(cnt_nrst), 32'd0);
    chk("t1_periods", 32'(periods), 32'd3);

    // 2: continuous period 2, then stop.
    start_run(2, 0, a);
    push_run(a, 2, 0, 3, 1'b0);
    repeat (10) step();
    chk("t2_count", 32'(count), 32'd0);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("t2_stop_busy", 32'(busy), 32'd0);
    step();
    chk("t2_count_cleared", 32'(count), 32'd0);
    chk("t2_periods", 32'(periods), 32'd3);

    // 3: stop coincides with the final tick.
    start_run(3, 2, a);
    push_run(a, 3, 2, 2, 1'b0);
    repeat (8) step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("t3_busy", 32'(busy), 32'd0);
    chk("t3_periods", 32'(periods), 32'd2);
    step();
    chk("t3_idle", 32'(busy), 32'd0);

    // 4a: period 0, tick every cycle.
    start_run(0, 4, a);
    push_run(a, 0, 4, 4, 1'b1);
    repeat (6) step();
    chk("t4a_busy", 32'(busy), 32'd0);
    chk("t4a_periods", 32'(periods), 32'd4);

    // 4b: maximum period, 16 cycles.
    start_run(15, 1, a);
    push_run(a, 15, 1, 1, 1'b1);
    repeat (18) step();
    chk("t4b_busy", 32'(busy), 32'd0);
    chk("t4b_periods", 32'(periods), 32'd1);

    // 5: start held high through repeated runs.
    period = 4'd1;
    reps   = 8'd1;
    start  = 1'b1;
    step();
    a = cyc;
    for (int r = 0; r < 3; r++) begin
      push_run(a, 1, 1, 1, 1'b1);
      repeat (3) step();
      if (r == 2) start = 1'b0;
      step();
      chk("t5_idle_gap", 32'(busy), 32'd0);
      step();
      chk("t5_rearm", 32'(busy), (r < 2) ? 32'd1 : 32'd0);
      a = cyc;
    end

    // 5b: start pulse during RUN is ignored.
    start_run(4, 1, a);
    push_run(a, 4, 1, 1, 1'b1);
    repeat (2) step();
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
    chk("t5b_busy", 32'(busy), 32'd0);
    chk("t5b_periods", 32'(periods), 32'd1);

    // 6: asynchronous reset mid-RUN.
    start_run(7, 0, a);
    repeat (4) step();
    chk("t6_count", 32'(count), 32'd3);
    #2;
    nrst = 1'b0;
    #1;
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_periods", 32'(periods), 32'd0);
    chk("t6_nrst", 32'(cnt_nrst), 32'd0);
    chk("t6_tick", 32'(tick), 32'd0);
    #3;
    nrst = 1'b1;
    step();
    start_run(2, 1, a);
    push_run(a, 2, 1, 1, 1'b1);
    repeat (5) step();
    chk("t6_after_busy", 32'(busy), 32'd0);
    chk("t6_after_periods", 32'(periods), 32'd1);

    chk("tick_q_empty", 32'(tq.size()), 32'd0);
    chk("done_q_empty", 32'(dq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
